// File: rtl/bit_decoder_pkg.sv
// Shared constants and wire types for the Zba/Zbb/Zbs decoder.
// Opcode/funct encodings live apart from the record types they feed.
package bit_decoder_const_pkg;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] F7_SHADD   = 7'b0010000;
   localparam logic [6:0] F7_NEG     = 7'b0100000;
   localparam logic [6:0] F7_MINMAX  = 7'b0000101;
   localparam logic [6:0] F7_ROT     = 7'b0110000;
   localparam logic [6:0] F7_ZEXT    = 7'b0000100;
   localparam logic [6:0] F7_BCLR    = 7'b0100100;
   localparam logic [6:0] F7_BINV    = 7'b0110100;
   localparam logic [6:0] F7_BSET    = 7'b0010100;
   localparam logic [11:0] IMM_CLZ   = 12'h600;
   localparam logic [11:0] IMM_CTZ   = 12'h601;
   localparam logic [11:0] IMM_CPOP  = 12'h602;
   localparam logic [11:0] IMM_SEXTB = 12'h604;
   localparam logic [11:0] IMM_SEXTH = 12'h605;
   localparam logic [11:0] IMM_ORCB  = 12'h287;
   localparam logic [11:0] IMM_REV8  = 12'h698;
endpackage

package bit_decoder_pkg;
   typedef struct packed {
      logic sh1add;
      logic sh2add;
      logic sh3add;
   } zba_op_type;

   typedef struct packed {
      logic andn;
      logic orn;
      logic xnor_op;
      logic clz;
      logic ctz;
      logic cpop;
      logic max;
      logic maxu;
      logic min;
      logic minu;
      logic sext_b;
      logic sext_h;
      logic zext_h;
      logic rol;
      logic ror;
      logic orc_b;
      logic rev8;
   } zbb_op_type;

   typedef struct packed {
      logic bclr;
      logic bext;
      logic binv;
      logic bset;
   } zbs_op_type;

   typedef struct packed {
      zba_op_type bit_zba;
      zbb_op_type bit_zbb;
      zbs_op_type bit_zbs;
   } bit_op_type;

   typedef struct packed {
      logic [31:0] instr;
   } dec_in_t;

   typedef struct packed {
      bit_op_type  bit_op;
      logic        sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        is_bit;
   } dec_out_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;
endpackage

// File: rtl/bit_decoder_table.sv
// Combinational Zba/Zbb/Zbs decode of one RV32 instruction word.
module bit_decode_table
   import bit_decoder_pkg::*;
   import bit_decoder_const_pkg::*;
(
   input  dec_in_t  din,
   output dec_out_t dout
);
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rs2;
   logic [11:0] imm12;
   logic        shift;

   assign opc   = din.instr[6:0];
   assign f3    = din.instr[14:12];
   assign f7    = din.instr[31:25];
   assign rs2   = din.instr[24:20];
   assign imm12 = din.instr[31:20];

   always_comb begin
      dout     = '0;
      shift    = 1'b0;
      dout.rs1 = din.instr[19:15];
      dout.rs2 = rs2;
      dout.rd  = din.instr[11:7];
      if (opc == OPC_OP) begin
         unique case ({f7, f3})
            {F7_SHADD, 3'b010}:  dout.bit_op.bit_zba.sh1add = 1'b1;
            {F7_SHADD, 3'b100}:  dout.bit_op.bit_zba.sh2add = 1'b1;
            {F7_SHADD, 3'b110}:  dout.bit_op.bit_zba.sh3add = 1'b1;
            {F7_NEG, 3'b111}:    dout.bit_op.bit_zbb.andn = 1'b1;
            {F7_NEG, 3'b110}:    dout.bit_op.bit_zbb.orn = 1'b1;
            {F7_NEG, 3'b100}:    dout.bit_op.bit_zbb.xnor_op = 1'b1;
            {F7_MINMAX, 3'b110}: dout.bit_op.bit_zbb.max = 1'b1;
            {F7_MINMAX, 3'b111}: dout.bit_op.bit_zbb.maxu = 1'b1;
            {F7_MINMAX, 3'b100}: dout.bit_op.bit_zbb.min = 1'b1;
            {F7_MINMAX, 3'b101}: dout.bit_op.bit_zbb.minu = 1'b1;
            {F7_ROT, 3'b001}:    dout.bit_op.bit_zbb.rol = 1'b1;
            {F7_ROT, 3'b101}:    dout.bit_op.bit_zbb.ror = 1'b1;
            {F7_ZEXT, 3'b100}:   dout.bit_op.bit_zbb.zext_h = (rs2 == 5'd0);
            {F7_BCLR, 3'b001}:   dout.bit_op.bit_zbs.bclr = 1'b1;
            {F7_BCLR, 3'b101}:   dout.bit_op.bit_zbs.bext = 1'b1;
            {F7_BINV, 3'b001}:   dout.bit_op.bit_zbs.binv = 1'b1;
            {F7_BSET, 3'b001}:   dout.bit_op.bit_zbs.bset = 1'b1;
            default: ;
         endcase
      end else if (opc == OPC_IMM) begin
         // unary forms match the full imm12; shift forms only funct7
         unique case ({f3, imm12})
            {3'b001, IMM_CLZ}:   dout.bit_op.bit_zbb.clz = 1'b1;
            {3'b001, IMM_CTZ}:   dout.bit_op.bit_zbb.ctz = 1'b1;
            {3'b001, IMM_CPOP}:  dout.bit_op.bit_zbb.cpop = 1'b1;
            {3'b001, IMM_SEXTB}: dout.bit_op.bit_zbb.sext_b = 1'b1;
            {3'b001, IMM_SEXTH}: dout.bit_op.bit_zbb.sext_h = 1'b1;
            {3'b101, IMM_ORCB}:  dout.bit_op.bit_zbb.orc_b = 1'b1;
            {3'b101, IMM_REV8}:  dout.bit_op.bit_zbb.rev8 = 1'b1;
            default: ;
         endcase
         unique case ({f7, f3})
            {F7_ROT, 3'b101}: begin
               dout.bit_op.bit_zbb.ror = 1'b1;
               shift = 1'b1;
            end
            {F7_BCLR, 3'b001}: begin
               dout.bit_op.bit_zbs.bclr = 1'b1;
               shift = 1'b1;
            end
            {F7_BCLR, 3'b101}: begin
               dout.bit_op.bit_zbs.bext = 1'b1;
               shift = 1'b1;
            end
            {F7_BINV, 3'b001}: begin
               dout.bit_op.bit_zbs.binv = 1'b1;
               shift = 1'b1;
            end
            {F7_BSET, 3'b001}: begin
               dout.bit_op.bit_zbs.bset = 1'b1;
               shift = 1'b1;
            end
            default: ;
         endcase
      end
      dout.is_bit = |dout.bit_op;
      if (shift) begin
         dout.sel = 1'b1;
         dout.imm = {27'b0, rs2};
      end
   end
endmodule

// File: rtl/bit_decoder.sv
// Bit-manip decode stage: decode table feeding a 2-entry skid FIFO.
module bit_decoder
   import bit_decoder_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output bit_op_type  out_bit_op,
   output logic        out_sel,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_bit
);
   dec_in_t  din;
   dec_out_t dec;
   dec_out_t head;
   dec_out_t tail;
   state_t   state;
   state_t   state_nx;
   logic     accept;
   logic     consume;
   logic     ld_head;
   logic     ld_tail;
   logic     ld_shift;

   assign din.instr = in_instr;

   bit_decode_table u_table (
      .din  (din),
      .dout (dec)
   );

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ld_head  = 1'b0;
      ld_tail  = 1'b0;
      ld_shift = 1'b0;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         unique case (state)
            EMPTY: if (accept) begin
               state_nx = ONE;
               ld_head  = 1'b1;
            end
            ONE: begin
               if (accept && !consume) begin
                  state_nx = FULL;
                  ld_tail  = 1'b1;
               end else if (consume && !accept) begin
                  state_nx = EMPTY;
               end else if (accept && consume) begin
                  ld_head = 1'b1;
               end
            end
            FULL: if (consume) begin
               state_nx = ONE;
               ld_shift = 1'b1;
            end
            default: state_nx = EMPTY;
         endcase
      end
   end

   // ready comes only from the state register, never from out_ready
   always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (ld_head)       head <= dec;
         else if (ld_shift) head <= tail;
         if (ld_tail)       tail <= dec;
      end
   end

   assign out_bit_op = head.bit_op;
   assign out_sel    = head.sel;
   assign out_imm    = head.imm;
   assign out_rs1    = head.rs1;
   assign out_rs2    = head.rs2;
   assign out_rd     = head.rd;
   assign out_bit    = head.is_bit;
endmodule

// File: tb/tb_bit_decoder.sv
// Directed-vector bench for bit_decoder: decode table plus FIFO corner cases.
module tb_bit_decoder;
   import bit_decoder_pkg::*;

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] IMM = 7'b0010011;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   bit_op_type  out_bit_op;
   logic        out_sel;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_bit;

   int tests = 0;
   int fails = 0;

   bit_decoder dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bit_op (out_bit_op),
      .out_sel    (out_sel),
      .out_imm    (out_imm),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_rd     (out_rd),
      .out_bit    (out_bit)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] instr;
      bit_op_type  op;
      logic        sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7,
      input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] d, input logic [6:0] opc);
      return {f7, r2, r1, f3, d, opc};
   endfunction

   task automatic add(input string n, input logic [31:0] i,
      input bit_op_type e, input logic s, input logic [31:0] m,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
      vec_t v;
      v.name = n; v.instr = i; v.op = e; v.sel = s; v.imm = m;
      v.rs1 = r1; v.rs2 = r2; v.rd = d;
      tbl.push_back(v);
   endtask

   task automatic check_entry(input vec_t v);
      chk({v.name, " valid"}, 32'(out_valid), 32'd1);
      chk({v.name, " op"}, 32'(out_bit_op), 32'(v.op));
      chk({v.name, " bit"}, 32'(out_bit), 32'(v.op != '0));
      chk({v.name, " sel"}, 32'(out_sel), 32'(v.sel));
      chk({v.name, " imm"}, out_imm, v.imm);
      chk({v.name, " rs1"}, 32'(out_rs1), 32'(v.rs1));
      chk({v.name, " rs2"}, 32'(out_rs2), 32'(v.rs2));
      chk({v.name, " rd"}, 32'(out_rd), 32'(v.rd));
   endtask

   task automatic fill_full(input int a, input int b);
      @(negedge clock);
      out_ready = 1'b0; in_valid = 1'b1; in_instr = tbl[a].instr;
      @(negedge clock);
      in_instr = tbl[b].instr;
      @(negedge clock);
      chk("full in_ready", 32'(in_ready), 32'd0);
   endtask

   initial begin
      bit_op_type e;
      int n;
      e = '0; e.bit_zba.sh1add = 1'b1;
      add("sh1add", 32'h20C5A533, e, 1'b0, 0, 11, 12, 10);
      e = '0; e.bit_zbb.ctz = 1'b1;
      add("ctz", 32'h60159513, e, 1'b0, 0, 11, 1, 10);
      // clz x10,x11 encodes imm 0x600; 0x60159513 above is ctz
      e = '0; e.bit_zbb.clz = 1'b1;
      add("clz", 32'h60059513, e, 1'b0, 0, 11, 0, 10);
      e = '0; e.bit_zbs.bclr = 1'b1;
      add("bclri", 32'h48359513, e, 1'b1, 3, 11, 3, 10);
      e = '0;
      add("add", 32'h00B50533, e, 1'b0, 0, 10, 11, 10);
      e = '0; e.bit_zba.sh3add = 1'b1;
      add("sh3add", enc(7'b0010000, 3, 2, 3'b110, 1, OP), e, 1'b0, 0, 2, 3, 1);
      e = '0; e.bit_zbb.andn = 1'b1;
      add("andn", enc(7'b0100000, 3, 2, 3'b111, 1, OP), e, 1'b0, 0, 2, 3, 1);
      e = '0; e.bit_zbb.xnor_op = 1'b1;
      add("xnor", enc(7'b0100000, 4, 5, 3'b100, 6, OP), e, 1'b0, 0, 5, 4, 6);
      e = '0; e.bit_zbb.maxu = 1'b1;
      add("maxu", enc(7'b0000101, 7, 8, 3'b111, 9, OP), e, 1'b0, 0, 8, 7, 9);
      e = '0; e.bit_zbb.min = 1'b1;
      add("min", enc(7'b0000101, 7, 8, 3'b100, 9, OP), e, 1'b0, 0, 8, 7, 9);
      e = '0; e.bit_zbb.rol = 1'b1;
      add("rol", enc(7'b0110000, 1, 2, 3'b001, 3, OP), e, 1'b0, 0, 2, 1, 3);
      e = '0; e.bit_zbb.ror = 1'b1;
      add("ror", enc(7'b0110000, 1, 2, 3'b101, 3, OP), e, 1'b0, 0, 2, 1, 3);
      e = '0; e.bit_zbb.zext_h = 1'b1;
      add("zexth", enc(7'b0000100, 0, 2, 3'b100, 3, OP), e, 1'b0, 0, 2, 0, 3);
      e = '0;
      add("zexth rs2!=0", enc(7'b0000100, 1, 2, 3'b100, 3, OP), e, 1'b0, 0, 2, 1, 3);
      e = '0; e.bit_zbs.bext = 1'b1;
      add("bext", enc(7'b0100100, 9, 10, 3'b101, 11, OP), e, 1'b0, 0, 10, 9, 11);
      e = '0; e.bit_zbs.bset = 1'b1;
      add("bseti31", enc(7'b0010100, 31, 4, 3'b001, 5, IMM), e, 1'b1, 31, 4, 31, 5);
      e = '0; e.bit_zbb.ror = 1'b1;
      add("rori7", enc(7'b0110000, 7, 4, 3'b101, 5, IMM), e, 1'b1, 7, 4, 7, 5);
      e = '0; e.bit_zbs.bext = 1'b1;
      add("bexti0", enc(7'b0100100, 0, 4, 3'b101, 5, IMM), e, 1'b1, 0, 4, 0, 5);
      e = '0; e.bit_zbs.binv = 1'b1;
      add("binvi16", enc(7'b0110100, 16, 4, 3'b001, 5, IMM), e, 1'b1, 16, 4, 16, 5);
      e = '0; e.bit_zbb.cpop = 1'b1;
      add("cpop", enc(7'b0110000, 2, 6, 3'b001, 7, IMM), e, 1'b0, 0, 6, 2, 7);
      e = '0; e.bit_zbb.sext_b = 1'b1;
      add("sextb", enc(7'b0110000, 4, 6, 3'b001, 7, IMM), e, 1'b0, 0, 6, 4, 7);
      e = '0; e.bit_zbb.orc_b = 1'b1;
      add("orcb", enc(7'b0010100, 7, 6, 3'b101, 7, IMM), e, 1'b0, 0, 6, 7, 7);
      e = '0; e.bit_zbb.rev8 = 1'b1;
      add("rev8", enc(7'b0110100, 24, 6, 3'b101, 7, IMM), e, 1'b0, 0, 6, 24, 7);
      e = '0;
      add("imm603", enc(7'b0110000, 3, 6, 3'b001, 7, IMM), e, 1'b0, 0, 6, 3, 7);
      add("xori", enc(7'b0100000, 3, 2, 3'b100, 1, IMM), e, 1'b0, 0, 2, 3, 1);
      add("shadd imm", enc(7'b0010000, 3, 2, 3'b010, 1, IMM), e, 1'b0, 0, 2, 3, 1);
      n = tbl.size();

      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset bit_op", 32'(out_bit_op), 32'd0);
      chk("reset imm", out_imm, 32'd0);
      chk("reset rd", 32'(out_rd), 32'd0);

      // stream at full rate; first accept right after reset release
      out_ready = 1'b1;
      for (int i = 0; i <= n; i++) begin
         @(negedge clock);
         if (i == 0) reset = 1'b0;
         if (i > 0) begin
            check_entry(tbl[i-1]);
            chk("stream in_ready", 32'(in_ready), 32'd1);
         end
         if (i < n) begin
            in_valid = 1'b1;
            in_instr = tbl[i].instr;
         end else begin
            in_valid = 1'b0;
         end
         if (i == 0) begin
            #1 chk("no same-cycle valid", 32'(out_valid), 32'd0);
         end
      end
      @(negedge clock);
      chk("drain empty", 32'(out_valid), 32'd0);

      // back-pressure: A, B accepted, C stalls until A leaves
      out_ready = 1'b0; in_valid = 1'b1; in_instr = tbl[0].instr;
      @(negedge clock);
      chk("bp ready after A", 32'(in_ready), 32'd1);
      in_instr = tbl[3].instr;
      @(negedge clock);
      chk("bp ready after B", 32'(in_ready), 32'd0);
      check_entry(tbl[0]);
      in_instr = tbl[6].instr;
      @(negedge clock);
      chk("bp ready stall", 32'(in_ready), 32'd0);
      check_entry(tbl[0]);
      out_ready = 1'b1;
      @(negedge clock);
      check_entry(tbl[3]);
      chk("bp ready reopen", 32'(in_ready), 32'd1);
      @(negedge clock);
      check_entry(tbl[6]);
      in_valid = 1'b0;
      @(negedge clock);
      chk("bp drained", 32'(out_valid), 32'd0);

      // flush while FULL, with a competing offer
      fill_full(0, 3);
      flush = 1'b1; in_instr = tbl[6].instr;
      @(negedge clock);
      chk("flush full valid", 32'(out_valid), 32'd0);
      chk("flush full ready", 32'(in_ready), 32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clock);
      chk("flush no stale", 32'(out_valid), 32'd0);

      // flush in ONE discards the same-cycle accept
      out_ready = 1'b0; in_valid = 1'b1; in_instr = tbl[0].instr;
      @(negedge clock);
      flush = 1'b1; in_instr = tbl[3].instr;
      @(negedge clock);
      chk("flush one valid", 32'(out_valid), 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      chk("flush one stays", 32'(out_valid), 32'd0);

      // asynchronous reset while FULL takes effect before the next edge
      fill_full(3, 0);
      in_instr = tbl[6].instr; out_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("async valid", 32'(out_valid), 32'd0);
      chk("async ready", 32'(in_ready), 32'd1);
      chk("async imm", out_imm, 32'd0);
      chk("async bit_op", 32'(out_bit_op), 32'd0);
      @(negedge clock);
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      chk("post reset empty", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
